// File: rtl/button_parser.sv
// Multi-channel button debouncer: 2-flop synchronizer, shared sample tick and a per-channel
// saturating qualify counter. Emits a debounced level and a one-cycle press pulse per channel.
module button_parser #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int PULSE_CNT_MAX  = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] out
);
    localparam int SW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int PW = (PULSE_CNT_MAX > 0) ? $clog2(PULSE_CNT_MAX + 1) : 1;
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
    localparam logic [PW-1:0] PULSE_FULL  = PW'(PULSE_CNT_MAX);

    logic [WIDTH-1:0]         sync1_q;
    logic [WIDTH-1:0]         sync2_q;
    logic [WIDTH-1:0]         level_q;
    logic [SW-1:0]            sample_cnt_q;
    logic [SW-1:0]            sample_cnt_d;
    logic                     tick;
    logic [WIDTH-1:0][PW-1:0] cnt_q;
    logic [WIDTH-1:0][PW-1:0] cnt_d;

    always_comb begin
        tick         = (sample_cnt_q == SAMPLE_LAST);
        sample_cnt_d = tick ? '0 : sample_cnt_q + SW'(1);
    end

    // A low synchronized sample always wins, so any glitch restarts qualification.
    always_comb begin
        cnt_d = cnt_q;
        level = '0;
        out   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            level[i] = (cnt_q[i] == PULSE_FULL);
            out[i]   = level[i] & ~level_q[i];
            if (!sync2_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick && (cnt_q[i] < PULSE_FULL)) begin
                cnt_d[i] = cnt_q[i] + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sample_cnt_q <= '0;
            cnt_q        <= '0;
            level_q      <= '0;
        end else begin
            sync1_q      <= in;
            sync2_q      <= sync1_q;
            sample_cnt_q <= sample_cnt_d;
            cnt_q        <= cnt_d;
            level_q      <= level;
        end
    end
endmodule

// File: tb/tb_button_parser.sv
// Bench for button_parser (WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3): directed scenarios with a
// per-cycle comparison against a tick-counting behavioural model plus literal expectations.
module tb_button_parser;
    localparam int W    = 2;
    localparam int SMAX = 4;
    localparam int PMAX = 3;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [1:0] in_v = 2'b00;
    logic [1:0] level;
    logic [1:0] out;

    button_parser #(
        .WIDTH(W),
        .SAMPLE_CNT_MAX(SMAX),
        .PULSE_CNT_MAX(PMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in(in_v),
        .level(level),
        .out(out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: synchronizer delay line, cycle phase since reset, and the number of sample
    // ticks seen during the current unbroken high run of each synchronized bit.
    int       m_phase;
    int       m_run [2];
    bit [1:0] m_s1;
    bit [1:0] m_s2;
    bit [1:0] m_lq;

    int pulses [2];
    int last_pulse [2];
    int last_tick;
    int n_ticks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic bit [1:0] exp_level();
        bit [1:0] e;
        for (int ch = 0; ch < 2; ch++) e[ch] = (m_run[ch] >= PMAX);
        return e;
    endfunction

    function automatic bit exp_tick();
        return (m_phase == SMAX - 1);
    endfunction

    task automatic model_clear();
        m_phase  = 0;
        m_s1     = 2'b00;
        m_s2     = 2'b00;
        m_lq     = 2'b00;
        m_run[0] = 0;
        m_run[1] = 0;
    endtask

    task automatic model_step();
        bit tk;
        if (rst) begin
            model_clear();
        end else begin
            tk   = exp_tick();
            m_lq = exp_level();
            for (int ch = 0; ch < 2; ch++) begin
                if (!m_s2[ch]) m_run[ch] = 0;
                else if (tk) m_run[ch] = (m_run[ch] >= PMAX) ? PMAX : m_run[ch] + 1;
            end
            m_s2    = m_s1;
            m_s1    = in_v;
            m_phase = (m_phase + 1) % SMAX;
        end
    endtask

    task automatic compare_all();
        check("level", 32'(level), 32'(exp_level()));
        check("out", 32'(out), 32'(exp_level() & ~m_lq));
        check("tick", 32'(dut.tick), 32'(exp_tick()));
    endtask

    // One clock: model advances on the edge, DUT sampled 2 ns later, returns at the falling edge.
    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step();
        #2;
        compare_all();
        for (int ch = 0; ch < 2; ch++) begin
            if (out[ch] === 1'b1) begin
                pulses[ch]++;
                last_pulse[ch] = cyc;
            end
        end
        if (dut.tick === 1'b1) begin
            n_ticks++;
            if (last_tick >= 0) check("tick_spacing", 32'(cyc - last_tick), 32'(SMAX));
            last_tick = cyc;
        end
        @(negedge clk);
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        model_clear();
        last_tick = -1;
        #1;
        compare_all();
    endtask

    task automatic wait_level(input bit [1:0] mask, input int t0, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if ((level & mask) == mask) got = 1'b1;
        end
        check_range(name, cyc - t0, 11, 14);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1, t0, nt;
        model_clear();
        last_tick     = -1;
        n_ticks       = 0;
        pulses[0]     = 0;
        pulses[1]     = 0;
        last_pulse[0] = -1;
        last_pulse[1] = -1;
        @(negedge clk);

        // Idle after reset: no level/out, one tick per 4 cycles
        assert_reset();
        repeat (3) cycle();
        rst = 1'b0;
        nt = n_ticks;
        p0 = pulses[0];
        p1 = pulses[1];
        repeat (48) cycle();
        check("idle_ticks", 32'(n_ticks - nt), 32'd12);
        check("idle_pulses", 32'(pulses[0] - p0 + pulses[1] - p1), 32'd0);
        check("idle_level", 32'(level), 32'd0);

        // Single held press: one pulse, release drops level one cycle after sync falls
        p0 = pulses[0];
        in_v = 2'b01;
        t0 = cyc;
        wait_level(2'b01, t0, "press_latency");
        check("press_out_first", 32'(out[0]), 32'd1);
        repeat (100) cycle();
        check("hold_pulses", 32'(pulses[0] - p0), 32'd1);
        in_v = 2'b00;
        repeat (2) cycle();
        check("release_level_hold", 32'(level[0]), 32'd1);
        cycle();
        check("release_level_drop", 32'(level[0]), 32'd0);
        repeat (5) cycle();

        // Glitch at cycle 6 of a 10-cycle press, then continued press requalifies from scratch
        p0 = pulses[0];
        for (int i = 0; i < 10; i++) begin
            in_v[0] = (i != 5);
            if (i == 6) t0 = cyc;
            cycle();
        end
        check("glitch_pulses", 32'(pulses[0] - p0), 32'd0);
        check("glitch_level", 32'(level[0]), 32'd0);
        wait_level(2'b01, t0, "requal_latency");
        check("requal_pulses", 32'(pulses[0] - p0), 32'd1);
        in_v = 2'b00;
        repeat (6) cycle();

        // Simultaneous press on both channels, then release channel 1 only
        p0 = pulses[0];
        p1 = pulses[1];
        in_v = 2'b11;
        t0 = cyc;
        wait_level(2'b11, t0, "dual_latency");
        check("dual_out", 32'(out), 32'd3);
        check("dual_pulse_cycle", 32'(last_pulse[0]), 32'(last_pulse[1]));
        in_v = 2'b01;
        repeat (4) cycle();
        check("indep_level", 32'(level), 32'd1);
        check("dual_pulses_ch0", 32'(pulses[0] - p0), 32'd1);
        check("dual_pulses_ch1", 32'(pulses[1] - p1), 32'd1);
        in_v = 2'b00;
        repeat (6) cycle();

        // Reset mid-qualification with the button held through release
        in_v = 2'b01;
        for (int i = 0; i < 20 && m_run[0] != 2; i++) cycle();
        check("reached_count_2", 32'(m_run[0]), 32'd2);
        assert_reset();
        check("rst_level_now", 32'(level), 32'd0);
        check("rst_out_now", 32'(out), 32'd0);
        repeat (2) cycle();
        p0 = pulses[0];
        rst = 1'b0;
        t0 = cyc;
        wait_level(2'b01, t0, "post_rst_latency");
        repeat (20) cycle();
        check("post_rst_pulses", 32'(pulses[0] - p0), 32'd1);
        in_v = 2'b00;
        repeat (6) cycle();

        // Press, release 20 cycles, press again: two pulses
        p0 = pulses[0];
        in_v = 2'b01;
        t0 = cyc;
        wait_level(2'b01, t0, "first_press_latency");
        repeat (3) cycle();
        in_v = 2'b00;
        repeat (20) cycle();
        in_v = 2'b01;
        t0 = cyc;
        wait_level(2'b01, t0, "second_press_latency");
        repeat (5) cycle();
        in_v = 2'b00;
        repeat (6) cycle();
        check("two_press_pulses", 32'(pulses[0] - p0), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_parser.md
BUTTON_PARSER -- requirements
Module: button_parser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the number of independent button channels.
REQ-002 The block SHALL have parameter SAMPLE_CNT_MAX, default 62500, giving sample-tick period in clk cycles (0.5 ms at 125 MHz, 8 ns clock).
REQ-003 The block SHALL have parameter PULSE_CNT_MAX, default 200, giving the number of consecutive high samples required to declare a press.
REQ-004 The block SHALL have port clk, input, 1 bit: sole clock, 125 MHz.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port in, input, WIDTH bits: raw asynchronous button levels, 1 = pressed.
REQ-007 The block SHALL have port level, output, WIDTH bits: debounced button state.
REQ-008 The block SHALL have port out, output, WIDTH bits: one-cycle pulse per debounced press, suitable as a counter ce.

Function
REQ-009 Each in bit SHALL pass through a 2-flop synchronizer; sync bit = second flop; input-to-sync latency 2 cycles.
REQ-010 A shared sample counter of width clog2(SAMPLE_CNT_MAX) SHALL count 0..SAMPLE_CNT_MAX-1 every cycle, then wrap to 0.
REQ-011 The sample tick SHALL be high for exactly the one cycle in which the sample counter equals SAMPLE_CNT_MAX-1: one tick per SAMPLE_CNT_MAX cycles.
REQ-012 Each channel SHALL own a saturating counter of width clog2(PULSE_CNT_MAX+1).
REQ-013 Per channel, if sync bit = 0, the counter SHALL clear to 0 on the next edge, regardless of tick.
REQ-014 Per channel, if sync bit = 1 and tick = 1 and counter < PULSE_CNT_MAX, the counter SHALL increment by 1.
REQ-015 Per channel, if sync bit = 1 and counter = PULSE_CNT_MAX, the counter SHALL hold and never wrap.
REQ-016 level[i] SHALL be 1 exactly when channel i counter = PULSE_CNT_MAX, decoded from registers with no combinational path from in.
REQ-017 A registered copy level_q SHALL follow level with 1-cycle delay.
REQ-018 out[i] SHALL equal level[i] AND NOT level_q[i]: high one cycle, coincident with the first cycle level[i] = 1.
REQ-019 Holding a button SHALL produce exactly one out pulse; a new pulse SHALL require level to fall and re-qualify.
REQ-020 Any single-cycle low glitch on the sync bit SHALL restart qualification from 0; release SHALL deassert level 1 cycle after sync falls.
REQ-021 Press-detect latency from a stable in rise SHALL lie in [2 + (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX + 1, 2 + PULSE_CNT_MAX*SAMPLE_CNT_MAX] cycles.
REQ-022 Channels SHALL be fully independent except for the shared tick; simultaneous presses SHALL yield simultaneous, independent out pulses.

Reset
REQ-023 Asserting rst SHALL asynchronously clear synchronizer flops, the sample counter, all channel counters and level_q to 0.
REQ-024 While rst = 1, level and out SHALL be 0.
REQ-025 Reset mid-qualification SHALL discard progress; after release, qualification SHALL restart from 0 with the sample counter at 0.
REQ-026 A button held through reset release SHALL produce exactly one out pulse after full requalification.

Verification (bench parameters: WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3)
REQ-027 The bench SHALL cover: reset then in=00 for 50 cycles -> level=00, out=00 throughout; tick observed every 4 cycles.
REQ-028 The bench SHALL cover: in[0] held 1 -> level[0] rises within 11..14 cycles of the in edge; out[0] high exactly 1 cycle; no further out[0] pulse over 100 held cycles.
REQ-029 The bench SHALL cover: in[0] high 10 cycles with a 1-cycle low at cycle 6 -> no level/out assertion; qualification restarts after the glitch.
REQ-030 The bench SHALL cover: in=11 asserted in the same cycle -> out[0] and out[1] pulse in the same cycle; release in[1] only -> level[1]=0 while level[0] stays 1.
REQ-031 The bench SHALL cover: rst pulsed while channel 0 counter = 2 -> level=00 immediately; with in held, a single out[0] pulse 11..14 cycles after rst release.
REQ-032 The bench SHALL cover: press, release for 20 cycles, press again -> exactly two out[0] pulses total.
